// File: rtl/random_range_sampler_pkg.sv
// Shared definitions for the random range sampler and its sibling consumer units.
package random_range_sampler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAW  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } sampler_state_e;

    localparam int unsigned DefaultMaxTries = 8;

endpackage

// File: rtl/random_range_mask.sv
// Combinational all-ones fill of a value: every bit at or below the highest set bit becomes 1.
module range_mask #(
    parameter int unsigned Width = 32
) (
    input  logic [Width-1:0] value_i,
    output logic [Width-1:0] mask_o
);

    logic [Width-1:0] fill;

    // Priority OR-cascade from the MSB downwards.
    always_comb begin
        fill = '0;
        fill[Width-1] = value_i[Width-1];
        for (int unsigned i = 1; i < Width; i++) begin
            fill[Width-1-i] = fill[Width-i] | value_i[Width-1-i];
        end
    end

    assign mask_o = fill;

endmodule

// File: rtl/random_range_sampler.sv
// Masked rejection sampler: maps raw generator words onto [0, limit) and drives the generator enable.
module random_range_sampler
    import random_range_sampler_pkg::*;
#(
    parameter int unsigned Width    = 32,
    parameter int unsigned MaxTries = DefaultMaxTries,
    parameter int unsigned TryBits  = 4
) (
    input  logic               clk,
    input  logic               rst,
    output logic               rnd_ce,
    input  logic [Width-1:0]   rnd_in,
    input  logic               req_valid,
    input  logic [Width-1:0]   req_limit,
    output logic               req_ready,
    output logic               out_valid,
    output logic [Width-1:0]   out_value,
    output logic               out_fallback,
    output logic [TryBits-1:0] out_tries,
    input  logic               out_ready
);

    localparam logic [TryBits-1:0] MaxTriesT = TryBits'(MaxTries);

    sampler_state_e     state_q, state_d;
    logic [Width-1:0]   limit_q, limit_d;
    logic [Width-1:0]   mask_q, mask_d;
    logic [Width-1:0]   value_q, value_d;
    logic               fallback_q, fallback_d;
    logic [TryBits-1:0] tries_q, tries_d;

    logic [Width-1:0]   req_mask;
    logic [Width-1:0]   cand;
    logic [TryBits-1:0] tries_inc;
    logic               idle_ready;

    range_mask #(
        .Width(Width)
    ) u_range_mask (
        .value_i(req_limit - Width'(1)),
        .mask_o (req_mask)
    );

    assign cand      = rnd_in & mask_q;
    assign tries_inc = tries_q + TryBits'(1);

    always_comb begin
        state_d    = state_q;
        limit_d    = limit_q;
        mask_d     = mask_q;
        value_d    = value_q;
        fallback_d = fallback_q;
        tries_d    = tries_q;
        idle_ready = 1'b0;
        rnd_ce     = 1'b0;
        out_valid  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                idle_ready = 1'b1;
                if (req_valid) begin
                    limit_d    = req_limit;
                    mask_d     = req_mask;
                    value_d    = '0;
                    fallback_d = 1'b0;
                    tries_d    = '0;
                    // limit 0 behaves as limit 1: the only legal result is 0, no draw needed.
                    state_d    = (req_limit <= Width'(1)) ? ST_DONE : ST_DRAW;
                end
            end
            ST_DRAW: begin
                rnd_ce  = 1'b1;
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (cand < limit_q) begin
                    value_d    = cand;
                    fallback_d = 1'b0;
                    state_d    = ST_DONE;
                end else if (tries_inc == MaxTriesT) begin
                    // cand < 2*limit, so the wrapped difference always lands in range.
                    value_d    = cand - limit_q;
                    fallback_d = 1'b1;
                    tries_d    = MaxTriesT;
                    state_d    = ST_DONE;
                end else begin
                    tries_d = tries_inc;
                    state_d = ST_DRAW;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            limit_q    <= '0;
            mask_q     <= '0;
            value_q    <= '0;
            fallback_q <= 1'b0;
            tries_q    <= '0;
        end else begin
            state_q    <= state_d;
            limit_q    <= limit_d;
            mask_q     <= mask_d;
            value_q    <= value_d;
            fallback_q <= fallback_d;
            tries_q    <= tries_d;
        end
    end

    assign req_ready    = idle_ready & rst;
    assign out_value    = value_q;
    assign out_fallback = fallback_q;
    assign out_tries    = tries_q;

endmodule
